barrett_bit_parallel: RTL and testbench

Pipelined Barrett modular reducer computing r = x mod m for a modulus of bit length k, using a precomputed μ = ⌊2^(2k)/m⌋. It sits in the lattice-crypto arithmetic datapath (Dilithium, q = 8380417) behind multipliers whose double-width products it reduces. It is fully pipelined: one reduction accepted per cycle, fixed latency.

---
 rtl/multiplier_pkg.sv | 48 ++++
 rtl/params_pkg.sv | 11 +
 rtl/barrett_bp_mult.sv | 16 +
 rtl/barrett_bit_parallel.sv | 133 +++++++++++++
 tb/tb_barrett_bit_parallel.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Product-width and pipeline-stage typedefs for the Barrett reducer.
// The range_err stage fields exist only when BARRETT_BP_RANGE_CHECK_EN is defined.
package multiplier_pkg;

  import params_pkg::*;

  localparam int unsigned PROD_LENGTH  = 2 * DATA_LENGTH;
  localparam int unsigned EXT_LENGTH   = DATA_LENGTH + 1;
  // Shift amounts up to 2k with k saturated below 2**(SHAMT_LENGTH-2)
  localparam int unsigned SHAMT_LENGTH = $clog2(DATA_LENGTH) + 2;

  typedef logic [DATA_LENGTH-1:0]  word_t;
  typedef logic [PROD_LENGTH-1:0]  prod_t;
  typedef logic [SHAMT_LENGTH-1:0] shamt_t;

  // Stage 1 -> stage 2 payload
  typedef struct packed {
    logic   valid;
`ifdef BARRETT_BP_RANGE_CHECK_EN
    logic   range_err;
`endif
    word_t  x;
    word_t  q3;
    word_t  m;
    shamt_t k;
  } stage1_t;

  // Stage 2 -> stage 3 payload
  typedef struct packed {
    logic  valid;
`ifdef BARRETT_BP_RANGE_CHECK_EN
    logic  range_err;
`endif
    word_t r;
    word_t m;
  } stage2_t;

  // Clamp the bit-length bus to a small shift amount; anything too large
  // saturates, which keeps every derived shift (k+2, 2k) inside shamt_t.
  function automatic shamt_t sat_len(input word_t len);
    if ((len >> (SHAMT_LENGTH - 2)) != '0) begin
      sat_len = shamt_t'((2 ** (SHAMT_LENGTH - 2)) - 1);
    end else begin
      sat_len = shamt_t'(len);
    end
  endfunction

endpackage : multiplier_pkg

// File: rtl/params_pkg.sv
// Static configuration shared by integrators and benches: datapath width and
// the Dilithium modulus with its Barrett constant.
package params_pkg;

  localparam int unsigned DATA_LENGTH    = 64;
  localparam int unsigned MODULUS_LENGTH = 23;

  localparam logic [DATA_LENGTH-1:0] MODULUS = DATA_LENGTH'(64'd8380417);
  localparam logic [DATA_LENGTH-1:0] MU      = DATA_LENGTH'(64'd8396807);

endpackage : params_pkg

// File: rtl/barrett_bp_mult.sv
// Combinational DATA_LENGTH x DATA_LENGTH unsigned multiplier, full-width product.
module barrett_bp_mult
  import params_pkg::*;
  import multiplier_pkg::*;
(
  input  logic [DATA_LENGTH-1:0] a_i,
  input  logic [DATA_LENGTH-1:0] b_i,
  output logic [PROD_LENGTH-1:0] p_o
);

  // Full-width unsigned product
  always_comb begin
    p_o = prod_t'(a_i) * prod_t'(b_i);
  end

endmodule : barrett_bp_mult

// File: rtl/barrett_bit_parallel.sv
// Three-stage pipelined Barrett reducer: result_o = x_i mod m_i, one item per
// cycle, fixed latency. Optional BARRETT_BP_RANGE_CHECK_EN adds range_err_o,
// flagging items with x >= 2^(2k) or k > DATA_LENGTH/2.
module barrett_bit_parallel
  import params_pkg::*;
  import multiplier_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] mu_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   valid_o,
`ifdef BARRETT_BP_RANGE_CHECK_EN
  output logic                   range_err_o,
`endif
  output logic [DATA_LENGTH-1:0] result_o
);

  stage1_t s1_d, s1_q;
  stage2_t s2_d, s2_q;
  logic    valid_d, valid_q;
  word_t   result_d, result_q;
`ifdef BARRETT_BP_RANGE_CHECK_EN
  logic    range_err_d, range_err_q;
`endif

  shamt_t k_in;
  word_t  q1;
  prod_t  q2;
  prod_t  q3m;

  logic [EXT_LENGTH-1:0] r_ext;
  logic [EXT_LENGTH-1:0] m1_ext;
  logic [EXT_LENGTH-1:0] m2_ext;

  // Stage 1 inputs: clamped bit length and q1 = x >> (k-1)
  always_comb begin
    k_in = sat_len(m_bl_i);
    q1   = x_i >> (k_in - shamt_t'(1));
  end

  barrett_bp_mult u_mult_q2 (
    .a_i (q1),
    .b_i (mu_i),
    .p_o (q2)
  );

  // Stage 1: q3 = (q1 * mu) >> (k+1), carry x, m, k forward
  always_comb begin
    s1_d       = '0;
    s1_d.valid = valid_i;
    s1_d.x     = x_i;
    s1_d.m     = m_i;
    s1_d.k     = k_in;
    s1_d.q3    = word_t'(q2 >> (k_in + shamt_t'(1)));
`ifdef BARRETT_BP_RANGE_CHECK_EN
    s1_d.range_err = valid_i &&
                     ((k_in > shamt_t'(DATA_LENGTH / 2)) ||
                      ((x_i >> {k_in, 1'b0}) != '0));
`endif
  end

  barrett_bp_mult u_mult_qm (
    .a_i (s1_q.q3),
    .b_i (s1_q.m),
    .p_o (q3m)
  );

  // Stage 2: r = (x - q3*m) mod 2^(k+2); the true remainder is below 3m
  always_comb begin
    prod_t mask;
    mask       = (prod_t'(1) << (s1_q.k + shamt_t'(2))) - prod_t'(1);
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.m     = s1_q.m;
    s2_d.r     = word_t'((prod_t'(s1_q.x) - q3m) & mask);
`ifdef BARRETT_BP_RANGE_CHECK_EN
    s2_d.range_err = s1_q.range_err;
`endif
  end

  // Stage 3: up to two conditional subtractions, resolved with parallel compares
  always_comb begin
    r_ext    = {1'b0, s2_q.r};
    m1_ext   = {1'b0, s2_q.m};
    m2_ext   = {s2_q.m, 1'b0};
    valid_d  = s2_q.valid;
    result_d = result_q;
    if (s2_q.valid) begin
      if (r_ext >= m2_ext) begin
        result_d = word_t'(r_ext - m2_ext);
      end else if (r_ext >= m1_ext) begin
        result_d = word_t'(r_ext - m1_ext);
      end else begin
        result_d = s2_q.r;
      end
    end
`ifdef BARRETT_BP_RANGE_CHECK_EN
    range_err_d = s2_q.valid && s2_q.range_err;
`endif
  end

  // Pipeline registers; reset flushes every in-flight item
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q        <= '0;
      s2_q        <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
`ifdef BARRETT_BP_RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
`ifdef BARRETT_BP_RANGE_CHECK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
`ifdef BARRETT_BP_RANGE_CHECK_EN
  assign range_err_o = range_err_q;
`endif

endmodule : barrett_bit_parallel

// File: tb/tb_barrett_bit_parallel.sv
// Scoreboard bench for barrett_bit_parallel: expectations are queued per
// driven cycle and retired three cycles later on the falling edge.
module tb_barrett_bit_parallel;

  import params_pkg::*;

  localparam int unsigned DL = DATA_LENGTH;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          valid_i = 1'b0;
  logic [DL-1:0] x_i = '0;
  logic [DL-1:0] m_i = MODULUS;
  logic [DL-1:0] mu_i = MU;
  logic [DL-1:0] m_bl_i = DL'(MODULUS_LENGTH);
  logic          valid_o;
  logic [DL-1:0] result_o;
`ifdef BARRETT_BP_RANGE_CHECK_EN
  logic          range_err_o;
`endif

  always #5 clk_i = ~clk_i;

  barrett_bit_parallel dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .x_i      (x_i),
    .m_i      (m_i),
    .mu_i     (mu_i),
    .m_bl_i   (m_bl_i),
    .valid_o  (valid_o),
`ifdef BARRETT_BP_RANGE_CHECK_EN
    .range_err_o (range_err_o),
`endif
    .result_o (result_o)
  );

  typedef struct {
    logic          valid;
    logic          chk_res;
    logic          rerr;
    logic [DL-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic in_range(input logic [DL-1:0] x);
    logic [127:0] xw;
    xw = {64'd0, x};
    in_range = (m_bl_i <= DL'(DL / 2)) && ((xw >> (2 * m_bl_i)) == 128'd0);
  endfunction

  function automatic exp_t mk_exp(input logic v, input logic [DL-1:0] x);
    exp_t e;
    e.valid   = v;
    e.chk_res = v && in_range(x);
    e.rerr    = v && !in_range(x);
    e.res     = x % m_i;
    return e;
  endfunction

  // One stimulus cycle: inputs change 1 time unit after the rising edge
  task automatic drive(input logic v, input logic [DL-1:0] x);
    @(posedge clk_i);
    #1;
    valid_i = v;
    x_i     = x;
    sb.push_back(mk_exp(v, x));
  endtask

  // Drain the pipe with bubbles, then load a new modulus while it is empty
  task automatic set_mod(input logic [DL-1:0] m, input int unsigned k);
    logic [127:0] one;
    repeat (4) drive(1'b0, '0);
    one    = 128'd1;
    m_i    = m;
    m_bl_i = DL'(k);
    mu_i   = DL'((one << (2 * k)) / {64'd0, m});
  endtask

  task automatic run_random(input int unsigned n, input int unsigned k);
    logic [DL-1:0] x;
    logic [127:0]  lim;
    for (int i = 0; i < int'(n); i++) begin
      lim = (128'd1 << (2 * k)) - 128'd1;
      x   = {$urandom, $urandom};
      x   = x & DL'(lim);
      drive($urandom_range(0, 3) != 0, x);
    end
  endtask

  // Retire one expectation per cycle once three later cycles are queued
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (sb.size() >= 4) begin
        e = sb.pop_front();
        check_eq("valid_o", DL'(valid_o), DL'(e.valid));
        if (e.valid && e.chk_res) check_eq("result_o", result_o, e.res);
`ifdef BARRETT_BP_RANGE_CHECK_EN
        if (e.valid) check_eq("range_err_o", DL'(range_err_o), DL'(e.rerr));
`endif
      end else begin
        check_eq("valid_o_fill", DL'(valid_o), '0);
      end
    end
  end

  initial begin
    logic [DL-1:0] xa;
    logic [DL-1:0] xd;

    #2 rst_ni = 1'b0;
    #2;
    check_eq("reset_valid_o", DL'(valid_o), '0);
    check_eq("reset_result_o", result_o, '0);
`ifdef BARRETT_BP_RANGE_CHECK_EN
    check_eq("reset_range_err_o", DL'(range_err_o), '0);
`endif
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;

    // Directed points for q = 8380417
    drive(1'b1, DL'(64'd0));
    drive(1'b1, DL'(64'd8380416));
    drive(1'b1, DL'(64'd8380417));
    drive(1'b1, DL'(64'd16777216));
    drive(1'b1, DL'(64'd70231372333056));
    drive(1'b0, DL'(64'd5));
    drive(1'b1, DL'(64'd70368744177663));
`ifdef BARRETT_BP_RANGE_CHECK_EN
    drive(1'b1, DL'(64'd70368744177664));
`endif
    drive(1'b1, DL'(64'd1));

    // Random stream with bubbles
    run_random(1000, MODULUS_LENGTH);

    // Reset with items in flight: oldest item just reached the output
    xa = DL'(64'd123456789012);
    drive(1'b1, xa);
    drive(1'b1, DL'(64'd999999999));
    drive(1'b1, DL'(64'd31415926535));
    @(posedge clk_i);
    #1;
    check_eq("pre_reset_valid_o", DL'(valid_o), DL'(1));
    check_eq("pre_reset_result_o", result_o, xa % MODULUS);
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    #1;
    check_eq("async_reset_valid_o", DL'(valid_o), '0);
    check_eq("async_reset_result_o", result_o, '0);
    repeat (2) @(posedge clk_i);
    #3;
    xd      = DL'(64'd55555555555);
    rst_ni  = 1'b1;
    valid_i = 1'b1;
    x_i     = xd;
    sb.push_back(mk_exp(1'b1, xd));
    drive(1'b0, '0);
    drive(1'b1, DL'(64'd8380418));

    // Other moduli, including the smallest and largest bit lengths
    set_mod(DL'(64'd3), 2);
    run_random(40, 2);
    set_mod(DL'(64'd13), 4);
    run_random(60, 4);
    set_mod(DL'(64'd4294967291), 32);
    drive(1'b1, '1);
    drive(1'b1, DL'(64'd4294967291));
    run_random(200, 32);

    repeat (4) drive(1'b0, '0);
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_barrett_bit_parallel
